// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory freezes with timeout, plus saturating stall/flush statistics.
module hazard_stall_controller #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int WAIT_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        EX_MEM_Branch,
  input  logic        EX_MEM_Zero,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        MEM_WB_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic        mem_error
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(WAIT_TIMEOUT);
  localparam logic [1:0] LU_INIT_C = 2'(LU_STALL_CYCLES - 1);

  state_t      state_r;
  state_t      ret_state_r;
  logic [1:0]  lu_cnt_r;
  logic [7:0]  wait_cnt_r;

  logic        lu_hazard_s;
  logic        taken_s;
  logic        access_s;
  logic        mem_busy_s;
  logic        timeout_s;
  logic        flush_s;
  logic        lu_stall_s;
  state_t      eff_state_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    sat_inc = (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Hazard conditions; while frozen the resumed state decides the release cycle.
  always_comb begin
    lu_hazard_s = ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                  ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt));
    taken_s     = EX_MEM_Branch & EX_MEM_Zero;
    access_s    = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready;
    mem_busy_s  = access_s & (wait_cnt_r != TIMEOUT_C);
    timeout_s   = access_s & (wait_cnt_r == TIMEOUT_C);
    eff_state_s = (state_r == MEM_WAIT) ? ret_state_r : state_r;
    flush_s     = ~mem_busy_s & taken_s;
    if (eff_state_s == LU_STALL) begin
      lu_stall_s = ~mem_busy_s & ~taken_s;
    end else begin
      lu_stall_s = ~mem_busy_s & ~taken_s & lu_hazard_s;
    end
  end

  // Pipeline register controls: freeze beats flush beats load-use stall; reset disables all.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    if (rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (mem_busy_s) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (flush_s) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (lu_stall_s) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else begin
      PCWrite      = 1'b1;
    end
  end

  // Sequencer state, wait timer, sticky timeout flag and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      lu_cnt_r    <= 2'd0;
      wait_cnt_r  <= 8'd0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
      mem_error   <= 1'b0;
    end else begin
      if (mem_busy_s) begin
        // lu_cnt is held so an interrupted stall resumes where it left off
        state_r     <= MEM_WAIT;
        ret_state_r <= eff_state_s;
        wait_cnt_r  <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
        if (flush_s) begin
          state_r  <= RUN;
          lu_cnt_r <= 2'd0;
        end else if (lu_stall_s) begin
          if (eff_state_s == LU_STALL) begin
            if (lu_cnt_r <= 2'd1) begin
              state_r  <= RUN;
              lu_cnt_r <= 2'd0;
            end else begin
              state_r  <= LU_STALL;
              lu_cnt_r <= lu_cnt_r - 2'd1;
            end
          end else if (LU_STALL_CYCLES > 1) begin
            state_r  <= LU_STALL;
            lu_cnt_r <= LU_INIT_C;
          end else begin
            state_r  <= RUN;
          end
        end else begin
          state_r <= RUN;
        end
      end
      if (timeout_s) begin
        mem_error <= 1'b1;
      end else begin
        mem_error <= mem_error;
      end
      if (!PCWrite) begin
        stall_count <= sat_inc(stall_count);
      end else begin
        stall_count <= stall_count;
      end
      if (flush_s) begin
        flush_count <= sat_inc(flush_count);
      end else begin
        flush_count <= flush_count;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: two instances (default and LU_STALL_CYCLES=3/WAIT_TIMEOUT=8)
// share stimulus and are checked against an owed-cycles reference model.
module tb_hazard_stall_controller;

  typedef struct packed {
    logic [4:0]  en;   // PCWrite, IF_ID, ID_EX, EX_MEM, MEM_WB
    logic        bub;
    logic [2:0]  fl;   // IF_ID, ID_EX, EX_MEM flush
    logic [15:0] sc;
    logic [15:0] fc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lr = 1'b0, br = 1'b0, zr = 1'b0, mr = 1'b0, mw = 1'b0, rdy = 1'b1;
  logic [4:0] lrt = 5'd0, rs = 5'd0, rt = 5'd0;

  exp_t act [2];
  logic [4:0]  en0, en1;
  logic        bub0, bub1;
  logic [2:0]  fl0, fl1;
  logic [15:0] sc0, sc1, fc0, fc1;
  logic        err0, err1;

  int checks = 0;
  int errors = 0;

  // reference model state: owed stall cycles, frozen cycles so far, sticky error, counters
  int n_cyc [2] = '{1, 3};
  int wt    [2] = '{255, 8};
  int pend  [2];
  int waited[2];
  int m_err [2];
  int m_sc  [2];
  int m_fc  [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  hazard_stall_controller dut0 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(lr), .ID_EX_Rt(lrt), .IF_ID_Rs(rs), .IF_ID_Rt(rt),
    .EX_MEM_Branch(br), .EX_MEM_Zero(zr), .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw),
    .mem_ready(rdy), .PCWrite(en0[4]), .IF_ID_Write(en0[3]), .ID_EX_Write(en0[2]),
    .EX_MEM_Write(en0[1]), .MEM_WB_Write(en0[0]), .ID_EX_Bubble(bub0),
    .IF_ID_Flush(fl0[2]), .ID_EX_Flush(fl0[1]), .EX_MEM_Flush(fl0[0]),
    .stall_count(sc0), .flush_count(fc0), .mem_error(err0));

  hazard_stall_controller #(.LU_STALL_CYCLES(3), .WAIT_TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(lr), .ID_EX_Rt(lrt), .IF_ID_Rs(rs), .IF_ID_Rt(rt),
    .EX_MEM_Branch(br), .EX_MEM_Zero(zr), .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw),
    .mem_ready(rdy), .PCWrite(en1[4]), .IF_ID_Write(en1[3]), .ID_EX_Write(en1[2]),
    .EX_MEM_Write(en1[1]), .MEM_WB_Write(en1[0]), .ID_EX_Bubble(bub1),
    .IF_ID_Flush(fl1[2]), .ID_EX_Flush(fl1[1]), .EX_MEM_Flush(fl1[0]),
    .stall_count(sc1), .flush_count(fc1), .mem_error(err1));

  assign act[0] = '{en: en0, bub: bub0, fl: fl0, sc: sc0, fc: fc0, err: err0};
  assign act[1] = '{en: en1, bub: bub1, fl: fl1, sc: sc1, fc: fc1, err: err1};

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %h expected %h at %0t", name, inst, got, want, $time);
    end
  endtask

  task automatic compare(input int inst, input exp_t a, input exp_t e);
    check("ctl", inst, {23'd0, a.en, a.bub, a.fl}, {23'd0, e.en, e.bub, e.fl});
    check("stall_count", inst, {16'd0, a.sc}, {16'd0, e.sc});
    check("flush_count", inst, {16'd0, a.fc}, {16'd0, e.fc});
    check("mem_error", inst, {31'd0, a.err}, {31'd0, e.err});
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; waited[i] = 0; m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  // One cycle of the reference model for instance i, using the current inputs.
  task automatic model_step(input int i, output exp_t e);
    bit access, frozen, hz, tk;
    e = '{en: 5'h1F, bub: 1'b0, fl: 3'b000, sc: 16'(m_sc[i]), fc: 16'(m_fc[i]),
          err: 1'(m_err[i])};
    access = (mr || mw) && !rdy;
    frozen = access && (waited[i] < wt[i]);
    hz = lr && (lrt != 5'd0) && (lrt == rs || lrt == rt);
    tk = br && zr;
    if (frozen) begin
      e.en = 5'b00000;
      waited[i]++;
      m_sc[i] = sat(m_sc[i]);
    end else begin
      if (access) m_err[i] = 1;
      waited[i] = 0;
      if (tk) begin
        e.fl = 3'b111;
        m_fc[i] = sat(m_fc[i]);
        pend[i] = 0;
      end else if (pend[i] > 0 || hz) begin
        e.en = 5'b00111;
        e.bub = 1'b1;
        m_sc[i] = sat(m_sc[i]);
        pend[i] = (pend[i] > 0) ? pend[i] - 1 : n_cyc[i] - 1;
      end
    end
  endtask

  task automatic cyc(input logic lr_, input logic [4:0] lrt_, input logic [4:0] rs_,
                     input logic [4:0] rt_, input logic br_, input logic zr_,
                     input logic mr_, input logic mw_, input logic rdy_);
    exp_t e0, e1;
    @(posedge clk);
    #1;
    lr = lr_; lrt = lrt_; rs = rs_; rt = rt_; br = br_; zr = zr_;
    mr = mr_; mw = mw_; rdy = rdy_;
    model_step(0, e0);
    model_step(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) compare(i, act[i], '0);
  endtask

  // Async reset pulse landing between edges, with no scoreboard traffic that cycle.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    lr = 1'b0; lrt = 5'd0; rs = 5'd0; rt = 5'd0; br = 1'b0; zr = 1'b0;
    mr = 1'b0; mw = 1'b0; rdy = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e0, e1;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        compare(0, act[0], e0);
        compare(1, act[1], e1);
      end
    end
  end

  initial begin
    int budget;
    model_reset();
    #2 check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // load-use, then the same with Rt=0 (no hazard)
    cyc(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // taken branch in stall cycle 2
    cyc(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    // memory freeze 4 cycles with taken held; flush lands on release
    for (int k = 0; k < 4; k++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    // freeze interrupting a load-use stall
    cyc(1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // timeout for the WAIT_TIMEOUT=8 instance
    for (int k = 0; k < 9; k++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // async reset mid-LU_STALL
    cyc(1'b1, 5'd6, 5'd6, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mid_reset();
    idle(3);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 2) != 0));
    end
    idle(2);

    // saturation of stall_count
    for (int k = 0; k < 65540; k++) cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    budget = 0;
    while (q0.size() > 0 && budget < 5) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q0.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
